vga_bounce_box: RTL and testbench

Pixel-source stage between the VGA sync/timing generator and the DAC pins. It consumes the generator's pixel coordinates, visible flag and active-low syncs. It renders a bordered square over a solid background and moves the square once per frame, reversing direction at the screen edges. RGB and sync outputs are delayed by the same pipeline depth, so the two stay aligned at the connector.

---
 rtl/vga_bounce_box.sv | 145 ++++++++++++++
 tb/tb_vga_bounce_box.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_box.sv
// vga_bounce_box: pixel source that draws a bordered square bouncing around
// the visible area. Two register stages sit between the timing generator and
// the DAC pins; syncs travel through the same two stages so they stay aligned
// with the colour data.
module vga_bounce_box #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          BOX_SIZE     = 32,
  parameter int          STEP         = 2,
  parameter logic [11:0] BOX_COLOR    = 12'hF80,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h008
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       isVisible,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       _hSyncIn,
  input  logic       _vSyncIn,
  input  logic       freeze,
  output logic       _hSync,
  output logic       _vSync,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);

  // One axis of motion: returns {new_dir, new_pos}. 11-bit math, no wrap.
  function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                            input logic       dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] res;
    p = {1'b0, pos};
    if (dir) begin
      if (p + STEP_W + BOX_W > lim) res = {1'b0, 10'(lim - BOX_W)};
      else                          res = {1'b1, 10'(p + STEP_W)};
    end else begin
      if (p < STEP_W) res = {1'b1, 10'd0};
      else            res = {1'b0, 10'(p - STEP_W)};
    end
    return res;
  endfunction

  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        v_prev_q, v_prev_d;
  // armed_q: vsync has been seen high since reset. Without it, a vsync held
  // low across reset release would look like a falling edge against the
  // reset value of v_prev_q and move the box spuriously.
  logic        armed_q, armed_d;
  logic        vis1_q, vis1_d, in1_q, in1_d, edge1_q, edge1_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d;
  logic [11:0] rgb_q, rgb_d;

  logic        tick;
  logic        in_x, in_y;
  logic [10:0] x_w, y_w, bx_w, by_w;

  // Next-state: frame-tick motion, stage-1 hit test, stage-2 colour select.
  always_comb begin
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    v_prev_d = _vSyncIn;
    armed_d  = armed_q | _vSyncIn;
    tick     = v_prev_q & ~_vSyncIn & armed_q;

    // A tick while frozen is simply dropped.
    if (tick && !freeze) begin
      {dir_x_d, box_x_d} = step_axis(box_x_q, dir_x_q, H_LIM);
      {dir_y_d, box_y_d} = step_axis(box_y_q, dir_y_q, V_LIM);
    end

    // Stage 1 compares against the position held this cycle.
    x_w     = {1'b0, x};
    y_w     = {1'b0, y};
    bx_w    = {1'b0, box_x_q};
    by_w    = {1'b0, box_y_q};
    in_x    = (x_w >= bx_w) && (x_w < bx_w + BOX_W);
    in_y    = (y_w >= by_w) && (y_w < by_w + BOX_W);
    vis1_d  = isVisible;
    in1_d   = in_x && in_y;
    edge1_d = in1_d && ((x_w == bx_w) || (x_w == bx_w + BOX_W - 11'd1) ||
                        (y_w == by_w) || (y_w == by_w + BOX_W - 11'd1));
    hs1_d   = _hSyncIn;
    vs1_d   = _vSyncIn;

    // Stage 2: blank outside active video, border wins over fill.
    if (!vis1_q)      rgb_d = 12'h000;
    else if (edge1_q) rgb_d = BORDER_COLOR;
    else if (in1_q)   rgb_d = BOX_COLOR;
    else              rgb_d = BG_COLOR;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      box_x_q  <= 10'd0;
      box_y_q  <= 10'd0;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      v_prev_q <= 1'b1;
      armed_q  <= 1'b0;
      vis1_q   <= 1'b0;
      in1_q    <= 1'b0;
      edge1_q  <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      rgb_q    <= 12'h000;
    end else begin
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      v_prev_q <= v_prev_d;
      armed_q  <= armed_d;
      vis1_q   <= vis1_d;
      in1_q    <= in1_d;
      edge1_q  <= edge1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      rgb_q    <= rgb_d;
    end
  end

  assign {r, g, b} = rgb_q;
  assign _hSync    = hs2_q;
  assign _vSync    = vs2_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// tb_vga_bounce_box: directed bench. Two instances share the stimulus: the
// default one (STEP=2) and one with STEP=3 for the left-edge bounce case.
// Box positions are tracked by probing pixels around the expected corner.
module tb_vga_bounce_box;

  logic       clk = 1'b0;
  logic       rst;
  logic       isVisible;
  logic [9:0] x, y;
  logic       _hSyncIn, _vSyncIn, freeze;
  logic       hs0, vs0, hs3, vs3;
  logic [3:0] r0, g0, b0, r3, g3, b3;
  logic [11:0] rgb0, rgb3;

  int tests_run = 0;
  int tests_failed = 0;

  vga_bounce_box dut (
    .clk(clk), .rst(rst), .isVisible(isVisible), .x(x), .y(y),
    ._hSyncIn(_hSyncIn), ._vSyncIn(_vSyncIn), .freeze(freeze),
    ._hSync(hs0), ._vSync(vs0), .r(r0), .g(g0), .b(b0)
  );

  vga_bounce_box #(.STEP(3)) dut3 (
    .clk(clk), .rst(rst), .isVisible(isVisible), .x(x), .y(y),
    ._hSyncIn(_hSyncIn), ._vSyncIn(_vSyncIn), .freeze(freeze),
    ._hSync(hs3), ._vSync(vs3), .r(r3), .g(g3), .b(b3)
  );

  assign rgb0 = {r0, g0, b0};
  assign rgb3 = {r3, g3, b3};

  // Clock
  always #5 clk = ~clk;

  // Advance one clock; land 1 time unit after the edge for drive and sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one pixel and check the colour two clocks later.
  task automatic pix(input string tag, input bit sel, input int px, input int py,
                     input logic vis, input logic [11:0] exp);
    x = 10'(px);
    y = 10'(py);
    isVisible = vis;
    step();
    step();
    check(tag, sel ? rgb3 : rgb0, exp);
  endtask

  // Confirm the box top-left corner sits exactly at (bx,by).
  task automatic probe(input string tag, input bit sel, input int bx, input int by);
    pix({tag, "_left"}, sel, bx, by + 1, 1'b1, 12'hFFF);
    pix({tag, "_fill"}, sel, bx + 1, by + 1, 1'b1, 12'hF80);
    pix({tag, "_top"}, sel, bx + 1, by, 1'b1, 12'hFFF);
    if (bx > 0) pix({tag, "_lbg"}, sel, bx - 1, by + 1, 1'b1, 12'h008);
    if (by > 0) pix({tag, "_tbg"}, sel, bx + 1, by - 1, 1'b1, 12'h008);
  endtask

  // One vsync falling edge.
  task automatic tick();
    _vSyncIn = 1'b1;
    step();
    _vSyncIn = 1'b0;
    step();
    _vSyncIn = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic hp[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic vp[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic ip[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Reset with syncs low and a visible in-box pixel on the inputs.
    rst = 1'b1; freeze = 1'b1; isVisible = 1'b1; x = 10'd5; y = 10'd5;
    _hSyncIn = 1'b0; _vSyncIn = 1'b0;
    #2;
    step(); step(); step();
    check("rst_rgb", rgb0, 12'h000);
    check("rst_sync", {10'd0, hs0, vs0}, 12'h003);

    // Pipeline: outputs hold reset for one more clock, then trail inputs by 2.
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        _hSyncIn = hp[i]; _vSyncIn = vp[i]; isVisible = ip[i];
      end
      step();
      if (i == 0) begin
        check("pipe_hold_rgb", rgb0, 12'h000);
        check("pipe_hold_sync", {10'd0, hs0, vs0}, 12'h003);
      end else begin
        check($sformatf("pipe_rgb_%0d", i - 1), rgb0, ip[i - 1] ? 12'hF80 : 12'h000);
        check($sformatf("pipe_sync_%0d", i - 1), {10'd0, hs0, vs0},
              {10'd0, hp[i - 1], vp[i - 1]});
      end
    end
    _hSyncIn = 1'b1; _vSyncIn = 1'b1;

    // Colours at box (0,0); frozen ticks above must not have moved it.
    pix("border_left", 0, 0, 10, 1'b1, 12'hFFF);
    pix("border_right", 0, 31, 10, 1'b1, 12'hFFF);
    pix("fill", 0, 10, 10, 1'b1, 12'hF80);
    pix("background", 0, 32, 10, 1'b1, 12'h008);
    pix("blank", 0, 10, 10, 1'b0, 12'h000);

    // Motion (STEP=2): Y clamps at 448, X at 608, then both come back.
    freeze = 1'b0;
    ticks(224); probe("t224", 0, 448, 448);
    tick();     probe("t225", 0, 450, 448);
    tick();     probe("t226", 0, 452, 446);
    ticks(78);  probe("t304", 0, 608, 290);
    tick();     probe("t305", 0, 608, 288);
    tick();     probe("t306", 0, 606, 286);

    // STEP=3 instance: X descends to 2, clamps to 0, then climbs to 3.
    ticks(99);  probe("s3_t405", 1, 2, 315);
    tick();     probe("s3_t406", 1, 0, 318);
    tick();     probe("s3_t407", 1, 3, 321);
    probe("t407", 0, 404, 84);

    // Freeze swallows ticks; release then one tick advances by STEP.
    freeze = 1'b1;
    ticks(10);  probe("frozen", 0, 404, 84);
    freeze = 1'b0;
    tick();     probe("unfrozen", 0, 402, 82);

    // Reset mid-line with vsync held low across release.
    rst = 1'b1; isVisible = 1'b1; x = 10'd5; y = 10'd5;
    _hSyncIn = 1'b0; _vSyncIn = 1'b0;
    step();
    check("mid_rst_rgb", rgb0, 12'h000);
    check("mid_rst_sync", {10'd0, hs0, vs0}, 12'h003);
    rst = 1'b0;
    step();
    check("mid_hold_rgb", rgb0, 12'h000);
    check("mid_hold_sync", {10'd0, hs0, vs0}, 12'h003);
    step();
    check("mid_first_rgb", rgb0, 12'hF80);
    check("mid_first_sync", {10'd0, hs0, vs0}, 12'h000);
    step(); step();
    _hSyncIn = 1'b1; _vSyncIn = 1'b1;
    probe("mid_home", 0, 0, 0);
    tick();     probe("mid_first_tick", 0, 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
